// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: opcodes, ALU codes and FSM states shared by the multi-cycle CPU.
package cpu_mc_pkg;
    localparam logic [3:0] OP_SYS  = 4'h0;
    localparam logic [3:0] OP_LB   = 4'h2;
    localparam logic [3:0] OP_SB   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_ANDI = 4'h6;
    localparam logic [3:0] OP_ORI  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_ALU  = 4'hF;
    localparam logic [2:0] FN_HALT = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_SLT = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_SRL = 3'd4;
    localparam logic [2:0] ALU_AND = 3'd5;
    localparam logic [2:0] ALU_OR  = 3'd6;
    localparam logic [2:0] ALU_NOT = 3'd7;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    function automatic logic writes_reg(input logic [3:0] op);
        return op inside {OP_ALU, OP_LB, OP_ADDI, OP_ANDI, OP_ORI};
    endfunction
endpackage

// File: rtl/cpu_mc_regfile.sv
// cpu_mc_regfile: 2-read/1-write register file, R0 reads as zero, async clear.
module cpu_mc_regfile
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [2:0]        ra_i,
    input  logic [2:0]        rb_i,
    input  logic              we_i,
    input  logic [2:0]        wa_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic [DATA_W-1:0] rda_o,
    output logic [DATA_W-1:0] rdb_o
);
    logic [DATA_W-1:0] r_q [NREG];

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)
            for (int i = 0; i < NREG; i++) r_q[i] <= '0;
        else if (we_i && wa_i != 3'd0 && int'(wa_i) < NREG)
            r_q[wa_i] <= wd_i;

    assign rda_o = (ra_i == 3'd0 || int'(ra_i) >= NREG) ? '0 : r_q[ra_i];
    assign rdb_o = (rb_i == 3'd0 || int'(rb_i) >= NREG) ? '0 : r_q[rb_i];
endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle 16-bit-instruction CPU with FETCH/DECODE/EXEC/MEM/WB/HALT
// sequencing and request/ready instruction and data buses.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int NREG   = 8
) (
    input  logic              CLK,
    input  logic              RESET_L,
    input  logic              EN_L,
    output logic              I_REQ,
    output logic [PC_W-1:0]   I_ADDR,
    input  logic              I_RDY,
    input  logic [15:0]       Iin,
    output logic              D_REQ,
    output logic              D_WE,
    output logic [DATA_W-1:0] D_ADDR,
    output logic [DATA_W-1:0] D_WDATA,
    input  logic              D_RDY,
    input  logic [DATA_W-1:0] D_RDATA,
    output logic [PC_W-1:0]   PC,
    output logic              HALTED
);
    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc, br_off;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [DATA_W-1:0] rda, rdb, imm, alu_b, alu_y;
    logic [3:0]        op;
    logic [2:0]        alu_fn;
    logic              is_halt, is_mem, taken, fire;

    assign op      = ir_q[15:12];
    assign imm     = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
    assign br_off  = {{(PC_W-7){ir_q[5]}}, ir_q[5:0], 1'b0};
    assign pc_inc  = pc_q + PC_W'(2);
    assign is_halt = op == OP_SYS && ir_q[2:0] == FN_HALT;
    assign is_mem  = op == OP_LB || op == OP_SB;
    assign taken   = (op == OP_BEQ && a_q == b_q) || (op == OP_BNE && a_q != b_q);
    assign fire    = I_REQ && I_RDY;
    assign alu_b   = op == OP_ALU ? b_q : imm;
    assign alu_fn  = op == OP_ALU ? ir_q[2:0] : op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : ALU_ADD;

    cpu_mc_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
        .clk_i (CLK),
        .rst_ni(RESET_L),
        .ra_i  (ir_q[11:9]),
        .rb_i  (ir_q[8:6]),
        .we_i  (state_q == S_WB && writes_reg(op)),
        .wa_i  (op == OP_ALU ? ir_q[5:3] : ir_q[8:6]),
        .wd_i  (res_q),
        .rda_o (rda),
        .rdb_o (rdb)
    );

    always_comb begin
        case (alu_fn)
            ALU_ADD: alu_y = a_q + alu_b;
            ALU_SUB: alu_y = a_q - alu_b;
            ALU_SLT: alu_y = DATA_W'($signed(a_q) < $signed(alu_b));
            ALU_XOR: alu_y = a_q ^ alu_b;
            ALU_SRL: alu_y = a_q >> 1;
            ALU_AND: alu_y = a_q & alu_b;
            ALU_OR:  alu_y = a_q | alu_b;
            default: alu_y = ~a_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L)
        if (!RESET_L) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = fire ? S_DECODE : S_FETCH;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = is_halt ? S_HALT : is_mem ? S_MEM : S_WB;
            S_MEM:    state_d = D_RDY ? S_WB : S_MEM;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = EN_L ? S_HALT : S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ir_d  = (state_q == S_FETCH && fire) ? Iin : ir_q;
        a_d   = state_q == S_DECODE ? rda : a_q;
        b_d   = state_q == S_DECODE ? rdb : b_q;
        res_d = state_q == S_EXEC ? alu_y : (state_q == S_MEM && D_RDY) ? D_RDATA : res_q;
        pc_d  = state_q == S_WB ? (op == OP_JMP ? a_q[PC_W-1:0] : taken ? pc_inc + br_off : pc_inc)
              : (state_q == S_HALT && !EN_L) ? pc_inc : pc_q;
    end

    // RESET_L gates I_REQ so the request stays low while reset holds the FSM in FETCH
    always_comb begin
        I_REQ   = state_q == S_FETCH && !EN_L && RESET_L;
        I_ADDR  = pc_q;
        D_REQ   = state_q == S_MEM;
        D_WE    = state_q == S_MEM && op == OP_SB;
        D_ADDR  = a_q + imm;
        D_WDATA = b_q;
        PC      = pc_q;
        HALTED  = state_q == S_HALT;
    end
endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: directed programs for cpu_mc with a store scoreboard and fetch-timing checks.
module tb_cpu_mc;
    logic        CLK = 0, RESET_L = 1, EN_L = 0, I_RDY = 1;
    logic        I_REQ, D_REQ, D_WE, D_RDY, HALTED;
    logic [7:0]  I_ADDR, PC, D_ADDR, D_WDATA, D_RDATA;
    logic [15:0] Iin;
    logic [15:0] imem [128];
    logic [7:0]  dmem [256];
    int          d_wait = 0, d_cnt = 0, cyc = 0, vectors = 0, errs = 0;

    typedef struct {logic [7:0] addr; logic [7:0] data;} st_t;
    st_t sb_q[$];

    cpu_mc #(.DATA_W(8), .PC_W(8), .NREG(8)) dut (
        .CLK(CLK), .RESET_L(RESET_L), .EN_L(EN_L),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDY(I_RDY), .Iin(Iin),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_RDY(D_RDY), .D_RDATA(D_RDATA), .PC(PC), .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    assign Iin     = imem[I_ADDR[7:1]];
    assign D_RDY   = D_REQ && (d_cnt >= d_wait);
    assign D_RDATA = dmem[D_ADDR];

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        d_cnt <= (D_REQ && !D_RDY) ? d_cnt + 1 : 0;
        if (D_REQ && D_WE && D_RDY) dmem[D_ADDR] <= D_WDATA;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin : store_mon
        st_t e;
        if (RESET_L && D_REQ && D_WE && D_RDY) begin
            vectors++;
            assert (sb_q.size() != 0) else begin
                errs++;
                $error("FAIL store_unexpected: observed %0h->[%0h] expected no store", D_WDATA, D_ADDR);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("store_addr", D_ADDR, e.addr);
                chk("store_data", D_WDATA, e.data);
            end
        end
    end

    function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb, input logic [5:0] imm);
        return {op, ra, rb, imm};
    endfunction

    function automatic logic [15:0] rr(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] fn);
        return {4'hF, ra, rb, rd, fn};
    endfunction

    function automatic int lat(input logic [15:0] w);
        return (w[15:12] == 4'h2 || w[15:12] == 4'h4) ? 5 : 4;
    endfunction

    task automatic put(input logic [7:0] a, input logic [15:0] w);
        imem[a[7:1]] = w;
    endtask

    task automatic exp_st(input logic [7:0] a, input logic [7:0] d);
        st_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
    endtask

    task automatic wait_fetch(input logic [7:0] pc, output int t);
        int n = 0;
        @(negedge CLK);
        while (!(I_REQ && I_RDY) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        assert (n < 60) else begin
            errs++;
            $error("FAIL fetch_timeout: observed addr %0h, expected fetch of %0h within 60 cycles", I_ADDR, pc);
        end
        chk("fetch_addr", I_ADDR, pc);
        chk("pc_out", PC, pc);
        t = cyc;
    endtask

    task automatic step(input logic [7:0] pc, input int gap, inout int t);
        int tn;
        wait_fetch(pc, tn);
        chk($sformatf("cycles_to_%0h", pc), tn - t, gap);
        t = tn;
    endtask

    initial begin
        int t, t1;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
        clear_imem();
        put(8'h00, ri(4'h5, 3'd0, 3'd1, 6'd5));
        put(8'h02, ri(4'h5, 3'd0, 3'd2, 6'h3D));
        put(8'h04, rr(3'd3, 3'd1, 3'd2, 3'd0));
        put(8'h06, rr(3'd4, 3'd2, 3'd1, 3'd1));
        put(8'h08, rr(3'd5, 3'd2, 3'd1, 3'd2));
        put(8'h0A, ri(4'h4, 3'd0, 3'd3, 6'd16)); exp_st(8'h10, 8'h02);
        put(8'h0C, ri(4'h4, 3'd0, 3'd4, 6'd17)); exp_st(8'h11, 8'hF8);
        put(8'h0E, ri(4'h4, 3'd0, 3'd5, 6'd18)); exp_st(8'h12, 8'h01);
        put(8'h10, rr(3'd7, 3'd1, 3'd2, 3'd3));
        put(8'h12, ri(4'h4, 3'd0, 3'd7, 6'd19)); exp_st(8'h13, 8'hF8);
        put(8'h14, rr(3'd7, 3'd2, 3'd0, 3'd4));
        put(8'h16, ri(4'h4, 3'd0, 3'd7, 6'd20)); exp_st(8'h14, 8'h7E);
        put(8'h18, rr(3'd7, 3'd1, 3'd2, 3'd5));
        put(8'h1A, ri(4'h4, 3'd0, 3'd7, 6'd21)); exp_st(8'h15, 8'h05);
        put(8'h1C, rr(3'd7, 3'd1, 3'd2, 3'd6));
        put(8'h1E, ri(4'h4, 3'd0, 3'd7, 6'd22)); exp_st(8'h16, 8'hFD);
        put(8'h20, 16'h0001);
        put(8'h22, rr(3'd7, 3'd1, 3'd0, 3'd7));
        put(8'h24, ri(4'h4, 3'd0, 3'd7, 6'd23)); exp_st(8'h17, 8'hFA);
        put(8'h26, ri(4'h6, 3'd2, 3'd7, 6'h0F));
        put(8'h28, ri(4'h4, 3'd0, 3'd7, 6'd24)); exp_st(8'h18, 8'h0D);
        put(8'h2A, ri(4'h7, 3'd1, 3'd7, 6'h30));
        put(8'h2C, ri(4'h4, 3'd0, 3'd7, 6'd25)); exp_st(8'h19, 8'hF5);
        put(8'h2E, rr(3'd0, 3'd1, 3'd1, 3'd0));
        put(8'h30, ri(4'h4, 3'd0, 3'd0, 6'd26)); exp_st(8'h1A, 8'h00);
        put(8'h32, rr(3'd7, 3'd1, 3'd2, 3'd2));
        put(8'h34, ri(4'h4, 3'd0, 3'd7, 6'd27)); exp_st(8'h1B, 8'h00);
        put(8'h36, ri(4'h4, 3'd0, 3'd1, 6'd6));  exp_st(8'h06, 8'h05);
        put(8'h38, ri(4'h2, 3'd0, 3'd6, 6'd6));
        put(8'h3A, ri(4'h4, 3'd0, 3'd6, 6'd7));  exp_st(8'h07, 8'h05);
        put(8'h3C, 16'h0000);
        put(8'h3E, ri(4'hB, 3'd1, 3'd7, 6'h3F));
        put(8'h40, 16'h0001);
        put(8'h42, ri(4'h4, 3'd0, 3'd7, 6'd28)); exp_st(8'h1C, 8'h00);

        #2 RESET_L = 0;
        #10;
        chk("rst_pc", PC, 8'h00);
        chk("rst_i_req", I_REQ, 1'b0);
        chk("rst_d_req", D_REQ, 1'b0);
        chk("rst_d_we", D_WE, 1'b0);
        chk("rst_halted", HALTED, 1'b0);
        @(posedge CLK);
        #1 RESET_L = 1;
        #1 chk("first_i_req", I_REQ, 1'b1);
        wait_fetch(8'h00, t);
        step(8'h02, 4, t);
        step(8'h04, 4, t);
        for (int a = 6; a <= 'h20; a += 2) step(8'(a), lat(imem[(a - 2) / 2]), t);

        @(posedge CLK);
        #1 EN_L = 1;
        repeat (10) @(negedge CLK);
        chk("halt_halted", HALTED, 1'b1);
        chk("halt_pc", PC, 8'h20);
        chk("halt_i_req", I_REQ, 1'b0);
        EN_L = 0;
        @(posedge CLK);
        #1 chk("resume_pc", PC, 8'h22);
        chk("resume_halted", HALTED, 1'b0);
        EN_L = 1;
        repeat (3) @(negedge CLK);
        chk("stall_i_req", I_REQ, 1'b0);
        chk("stall_pc", PC, 8'h22);
        @(posedge CLK);
        #1 EN_L = 0;
        wait_fetch(8'h22, t);
        for (int a = 'h24; a <= 'h38; a += 2) step(8'(a), lat(imem[(a - 2) / 2]), t);
        d_wait = 3;
        step(8'h3A, 8, t);
        d_wait = 0;
        for (int a = 'h3C; a <= 'h44; a += 2) step(8'(a), lat(imem[(a - 2) / 2]), t);
        chk("sb_drained_a", sb_q.size(), 0);

        RESET_L = 0;
        clear_imem();
        put(8'h00, ri(4'h5, 3'd0, 3'd1, 6'd5));
        put(8'h02, ri(4'h5, 3'd0, 3'd7, 6'd16));
        put(8'h04, ri(4'hA, 3'd7, 3'd0, 6'd0));
        put(8'h10, ri(4'h8, 3'd1, 3'd1, 6'h3E));
        put(8'h12, ri(4'h5, 3'd0, 3'd6, 6'h3E));
        put(8'h14, ri(4'hA, 3'd6, 3'd0, 6'd0));
        @(posedge CLK);
        #1 RESET_L = 1;
        wait_fetch(8'h00, t);
        wait_fetch(8'h02, t);
        wait_fetch(8'h04, t);
        wait_fetch(8'h10, t);
        @(posedge CLK);
        #1 put(8'h10, ri(4'h9, 3'd1, 3'd1, 6'h3E));
        wait_fetch(8'h0E, t);
        wait_fetch(8'h10, t);
        wait_fetch(8'h12, t);
        wait_fetch(8'h14, t);
        wait_fetch(8'hFE, t);
        wait_fetch(8'h00, t);

        RESET_L = 0;
        clear_imem();
        dmem[30] = 8'h5A;
        put(8'h00, ri(4'h5, 3'd0, 3'd1, 6'd9));
        put(8'h02, ri(4'h4, 3'd0, 3'd1, 6'd30));
        d_wait = 1000;
        @(posedge CLK);
        #1 RESET_L = 1;
        wait_fetch(8'h00, t);
        wait_fetch(8'h02, t1);
        repeat (3) @(negedge CLK);
        chk("mem_d_req", D_REQ, 1'b1);
        chk("mem_d_we", D_WE, 1'b1);
        chk("mem_d_addr", D_ADDR, 8'h1E);
        chk("mem_d_wdata", D_WDATA, 8'h09);
        #2 RESET_L = 0;
        #1 chk("abort_d_req", D_REQ, 1'b0);
        chk("abort_d_we", D_WE, 1'b0);
        chk("abort_pc", PC, 8'h00);
        repeat (2) @(negedge CLK);
        chk("abort_mem", dmem[30], 8'h5A);
        d_wait = 0;
        put(8'h00, ri(4'h4, 3'd0, 3'd1, 6'd31)); exp_st(8'h1F, 8'h00);
        put(8'h02, 16'h0001);
        @(posedge CLK);
        #1 RESET_L = 1;
        wait_fetch(8'h00, t);
        wait_fetch(8'h02, t1);
        chk("cycles_to_02_post_abort", t1 - t, 5);
        repeat (3) @(negedge CLK);
        chk("halt_en_low", HALTED, 1'b1);
        step(8'h04, 4, t1);
        chk("sb_drained_c", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
